// File: rtl/fifo_route_rx_if.sv
// Purpose: source-FIFO read port plus the two client-FIFO write ports
//          used by the packet router.
// Signals: fifo_rdempty/fifo_rden/fifo_rddata  - source FIFO read side
//          c1_wrfull/c1_wren/c1_wrdata         - client 1 write side
//          c2_wrfull/c2_wren/c2_wrdata         - client 2 write side
// Modports: master = router side, slave = FIFO/environment side.
interface fifo_route_rx_if #(
    parameter int unsigned DWIDTH = 8
);
    logic              fifo_rdempty;
    logic              fifo_rden;
    logic [DWIDTH-1:0] fifo_rddata;
    logic              c1_wrfull;
    logic              c1_wren;
    logic [DWIDTH-1:0] c1_wrdata;
    logic              c2_wrfull;
    logic              c2_wren;
    logic [DWIDTH-1:0] c2_wrdata;

    modport master (
        input  fifo_rdempty, fifo_rddata, c1_wrfull, c2_wrfull,
        output fifo_rden, c1_wren, c1_wrdata, c2_wren, c2_wrdata
    );

    modport slave (
        output fifo_rdempty, fifo_rddata, c1_wrfull, c2_wrfull,
        input  fifo_rden, c1_wren, c1_wrdata, c2_wren, c2_wrdata
    );
endinterface

// File: rtl/fifo_route_rx.sv
// Purpose: reads header-prefixed packets from a source FIFO and copies each
//          packet (header + payload) into one of two client FIFOs. The header
//          selects the client (SELMASK) and a 3-bit payload count code
//          (CNTMASK); reserved codes give a header-only packet and an err pulse.
// Ports:   CLK    - clock, rising edge
//          RESET  - synchronous active-high reset
//          bus    - source read / client write ports (master modport)
//          busy   - high while a packet is in progress
//          err    - one-cycle pulse on a reserved count code
module fifo_route_rx #(
    parameter int unsigned       DWIDTH  = 8,
    parameter logic [DWIDTH-1:0] SELMASK = DWIDTH'(8'h80),
    parameter logic [DWIDTH-1:0] CNTMASK = DWIDTH'(8'h70)
) (
    input  logic                   CLK,
    input  logic                   RESET,
    fifo_route_rx_if.master        bus,
    output logic                   busy,
    output logic                   err
);

    // Index of the lowest set bit of the count-code field.
    function automatic int low_bit(input logic [DWIDTH-1:0] m);
        int r;
        r = 0;
        for (int i = int'(DWIDTH) - 1; i >= 0; i--) begin
            if (m[i]) r = i;
        end
        return r;
    endfunction

    localparam int          CSHIFT = low_bit(CNTMASK);
    localparam int unsigned RW     = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        HWR  = 3'd2,
        PRD  = 3'd3,
        PWR  = 3'd4
    } state_e;

    state_e            state_q;
    logic [DWIDTH-1:0] hdr_q;
    logic              dst_c2_q;    // 0 = client 1, 1 = client 2
    logic [RW-1:0]     rem_q;

    logic [2:0]        code_c;
    logic [RW-1:0]     rem_dec_c;
    logic              bad_code_c;
    logic              sel_c1_c;
    logic              dst_full_c;
    logic              rden_c;
    logic              wren_c;
    logic [DWIDTH-1:0] wdata_c;

    // Header field extraction.
    assign code_c     = 3'(bus.fifo_rddata >> CSHIFT);
    assign sel_c1_c   = (bus.fifo_rddata & SELMASK) == SELMASK;
    assign dst_full_c = dst_c2_q ? bus.c2_wrfull : bus.c1_wrfull;

    // Count code to payload length; codes 5-7 are reserved.
    always_comb begin
        rem_dec_c  = '0;
        bad_code_c = 1'b0;
        case (code_c)
            3'd0:    rem_dec_c = RW'(0);
            3'd1:    rem_dec_c = RW'(1);
            3'd2:    rem_dec_c = RW'(2);
            3'd3:    rem_dec_c = RW'(4);
            3'd4:    rem_dec_c = RW'(8);
            default: bad_code_c = 1'b1;
        endcase
    end

    // Read/write strobes and write data; everything is forced low in reset.
    always_comb begin
        rden_c  = 1'b0;
        wren_c  = 1'b0;
        wdata_c = '0;
        if (!RESET) begin
            case (state_q)
                IDLE: rden_c = ~bus.fifo_rdempty;
                HWR: begin
                    wren_c  = ~dst_full_c;
                    wdata_c = hdr_q;
                end
                // Only read a payload word when its write is guaranteed room.
                PRD:  rden_c = ~bus.fifo_rdempty & ~dst_full_c;
                PWR: begin
                    wren_c  = 1'b1;
                    wdata_c = bus.fifo_rddata;
                end
                default: ;
            endcase
        end
    end

    assign bus.fifo_rden = rden_c;
    assign bus.c1_wren   = wren_c & ~dst_c2_q;
    assign bus.c2_wren   = wren_c &  dst_c2_q;
    assign bus.c1_wrdata = wdata_c;
    assign bus.c2_wrdata = wdata_c;
    assign busy          = ~RESET & (state_q != IDLE);
    assign err           = ~RESET & (state_q == HDR) & bad_code_c;

    // Packet sequencing FSM.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            hdr_q    <= '0;
            dst_c2_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (rden_c) state_q <= HDR;
                HDR: begin
                    hdr_q    <= bus.fifo_rddata;
                    dst_c2_q <= ~sel_c1_c;
                    rem_q    <= rem_dec_c;
                    state_q  <= HWR;
                end
                HWR: begin
                    if (!dst_full_c) begin
                        state_q <= (rem_q == '0) ? IDLE : PRD;
                    end
                end
                PRD: if (rden_c) state_q <= PWR;
                PWR: begin
                    rem_q   <= rem_q - RW'(1);
                    state_q <= (rem_q == RW'(1)) ? IDLE : PRD;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_route_rx.sv
// Purpose: self-checking bench for fifo_route_rx. A source-FIFO queue and
//          a packet-level reference model predict every client write, busy,
//          err and handshake rule; directed scenarios are followed by
//          randomized traffic with random client back-pressure and empties.
module tb_fifo_route_rx;

    logic CLK = 1'b0;
    logic RESET;
    logic busy;
    logic err;

    fifo_route_rx_if #(.DWIDTH(8)) bus ();

    fifo_route_rx dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.master),
        .busy  (busy),
        .err   (err)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Environment state
    logic [7:0] src_q[$];
    logic       stall_empty = 1'b0;
    logic       c1_full = 1'b0;
    logic       c2_full = 1'b0;
    logic       pend = 1'b0;
    logic [7:0] pend_data;

    // Reference model state (packet level)
    logic [7:0] exp_q[$];
    int         wr_left = 0;      // writes still owed for the current packet
    int         rd_left = 0;      // payload reads still owed
    logic       cur_dst2 = 1'b0;
    logic       hdr_written = 1'b0;
    logic       err_due = 1'b0;
    int         cyc = 0;
    int         hdr_rd_cyc = -10;
    int         pay_rd_cyc = -10;
    int         last_wr = -10;
    int         hdr_lat = 0;
    logic       last_rden = 1'b0;
    logic       last_w1 = 1'b0;
    logic       last_w2 = 1'b0;
    int         n_rd = 0, n_w1 = 0, n_w2 = 0, n_err = 0, n_err_exp = 0;

    function automatic int decode_cnt(input logic [7:0] h);
        int code;
        code = (int'(h) >> 4) & 7;
        if (code <= 2) return code;
        if (code <= 4) return 1 << (code - 1);
        return 0;
    endfunction

    task automatic model_reset();
        wr_left     = 0;
        rd_left     = 0;
        hdr_written = 1'b0;
        err_due     = 1'b0;
        pend        = 1'b0;
        exp_q.delete();
    endtask

    // One clock: drive inputs, sample/check at negedge, apply read data after posedge.
    task automatic step();
        logic       rden, w1, w2, wr2;
        logic [7:0] wd1, wd2, word, expw;
        int         cnt, code;
        bus.fifo_rdempty = (src_q.size() == 0) || stall_empty;
        bus.c1_wrfull    = c1_full;
        bus.c2_wrfull    = c2_full;
        @(negedge CLK);
        cyc++;
        rden = bus.fifo_rden;
        w1   = bus.c1_wren;
        w2   = bus.c2_wren;
        wd1  = bus.c1_wrdata;
        wd2  = bus.c2_wrdata;
        last_rden = 1'b0;
        last_w1   = w1;
        last_w2   = w2;
        if (err) n_err++;
        if (RESET) begin
            chk("rst_strobes", {27'd0, rden, w1, w2, busy, err}, 32'd0);
            chk("rst_wrdata", {16'd0, wd1, wd2}, 32'd0);
            model_reset();
        end else begin
            chk("busy", 32'(busy), 32'(wr_left > 0));
            chk("err", 32'(err), 32'(err_due));
            err_due = 1'b0;
            chk("wrdata_same", 32'(wd1), 32'(wd2));
            chk("one_wren", 32'(w1 & w2), 32'd0);
            if (w1 || w2) begin
                wr2 = w2;
                chk("wren_dst", 32'(wr2), 32'(cur_dst2));
                chk("wren_full", 32'(wr2 ? c2_full : c1_full), 32'd0);
                chk("wr_spacing", 32'(cyc - last_wr >= 2), 32'd1);
                last_wr = cyc;
                if (exp_q.size() == 0) chk("wr_extra", 32'd1, 32'd0);
                else begin
                    expw = exp_q.pop_front();
                    chk("wdata", 32'(wd1), 32'(expw));
                end
                if (!hdr_written) begin
                    hdr_lat = cyc - hdr_rd_cyc;
                    chk("hdr_lat", 32'(hdr_lat >= 2), 32'd1);
                    hdr_written = 1'b1;
                end else begin
                    chk("pay_lat", 32'(cyc - pay_rd_cyc), 32'd1);
                end
                wr_left--;
                if (wr2) n_w2++; else n_w1++;
            end else if (wr_left == 0 || hdr_written || cyc == hdr_rd_cyc + 1) begin
                chk("wrdata_idle", 32'(wd1), 32'd0);
            end
            if (rden) begin
                last_rden = 1'b1;
                n_rd++;
                chk("rd_empty", 32'(bus.fifo_rdempty), 32'd0);
                word = (src_q.size() > 0) ? src_q.pop_front() : 8'($urandom);
                pend      = 1'b1;
                pend_data = word;
                if (wr_left == 0) begin
                    code        = (int'(word) >> 4) & 7;
                    cnt         = decode_cnt(word);
                    cur_dst2    = (word & 8'h80) != 8'h80;
                    err_due     = code >= 5;
                    if (code >= 5) n_err_exp++;
                    wr_left     = 1 + cnt;
                    rd_left     = cnt;
                    hdr_written = 1'b0;
                    hdr_rd_cyc  = cyc;
                    exp_q.push_back(word);
                end else begin
                    chk("rd_dst_full", 32'(cur_dst2 ? c2_full : c1_full), 32'd0);
                    chk("rd_over", 32'(rd_left > 0), 32'd1);
                    rd_left--;
                    pay_rd_cyc = cyc;
                    exp_q.push_back(word);
                end
            end
        end
        @(posedge CLK);
        #1;
        bus.fifo_rddata = pend ? pend_data : 8'($urandom);
        pend = 1'b0;
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while (!(src_q.size() == 0 && wr_left == 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk("timeout", 32'd1, 32'd0);
        step();
        step();
    endtask

    task automatic push(input logic [7:0] b);
        src_q.push_back(b);
    endtask

    int b_rd, b_w1, b_w2, b_err, guard;
    logic [7:0] h;

    initial begin
        RESET = 1'b1;
        bus.fifo_rddata = '0;
        step();
        step();
        RESET = 1'b0;
        step();

        // Single header-only packet to client 1
        b_rd = n_rd; b_w1 = n_w1; b_w2 = n_w2;
        push(8'h80);
        run_idle(50);
        chk("t1_rd", 32'(n_rd - b_rd), 32'd1);
        chk("t1_c1", 32'(n_w1 - b_w1), 32'd1);
        chk("t1_c2", 32'(n_w2 - b_w2), 32'd0);
        chk("t1_lat", 32'(hdr_lat), 32'd2);

        // Four-byte packet to client 2
        b_rd = n_rd; b_w1 = n_w1; b_w2 = n_w2;
        push(8'h30); push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
        run_idle(100);
        chk("t2_rd", 32'(n_rd - b_rd), 32'd5);
        chk("t2_c2", 32'(n_w2 - b_w2), 32'd5);
        chk("t2_c1", 32'(n_w1 - b_w1), 32'd0);

        // Eight-byte packet with client 1 full for 10 cycles after 3rd payload write
        b_rd = n_rd; b_w1 = n_w1;
        push(8'hC0);
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        guard = 0;
        while (n_w1 - b_w1 < 4 && guard < 100) begin step(); guard++; end
        chk("t3_reach", 32'(n_w1 - b_w1), 32'd4);
        c1_full = 1'b1;
        b_err = n_rd;
        guard = n_w1;
        repeat (10) step();
        chk("t3_stall_rd", 32'(n_rd), 32'(b_err));
        chk("t3_stall_wr", 32'(n_w1), 32'(guard));
        c1_full = 1'b0;
        run_idle(100);
        chk("t3_c1", 32'(n_w1 - b_w1), 32'd9);
        chk("t3_rd", 32'(n_rd - b_rd), 32'd9);

        // Reserved code: header-only to client 2, next byte is a fresh header
        b_w1 = n_w1; b_w2 = n_w2; b_err = n_err;
        push(8'h50); push(8'h90); push(8'h5A);
        run_idle(100);
        chk("t4_err", 32'(n_err - b_err), 32'd1);
        chk("t4_c2", 32'(n_w2 - b_w2), 32'd1);
        chk("t4_c1", 32'(n_w1 - b_w1), 32'd2);

        // Source empty for 5 cycles mid-payload
        b_w2 = n_w2;
        push(8'h30); push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        guard = 0;
        while (n_w2 - b_w2 < 2 && guard < 100) begin step(); guard++; end
        stall_empty = 1'b1;
        b_rd = n_rd;
        repeat (5) step();
        chk("t5_stall_rd", 32'(n_rd), 32'(b_rd));
        chk("t5_busy", 32'(busy), 32'd1);
        stall_empty = 1'b0;
        run_idle(100);
        chk("t5_c2", 32'(n_w2 - b_w2), 32'd5);

        // Reset during a payload write; the packet is abandoned
        b_rd = n_rd;
        push(8'h30); push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        guard = 0;
        while (!(n_rd - b_rd == 3 && last_rden) && guard < 100) begin step(); guard++; end
        chk("t6_reach", 32'(n_rd - b_rd), 32'd3);
        RESET = 1'b1;
        src_q.delete();
        step();
        RESET = 1'b0;
        b_rd = n_rd; b_w1 = n_w1; b_w2 = n_w2;
        push(8'h80);
        run_idle(50);
        chk("t6_c1", 32'(n_w1 - b_w1), 32'd1);
        chk("t6_c2", 32'(n_w2 - b_w2), 32'd0);
        chk("t6_rd", 32'(n_rd - b_rd), 32'd1);

        // Randomized traffic with back-pressure and source gaps
        for (int p = 0, s = 0; s < 4000 && (p < 60 || src_q.size() > 0); s++) begin
            if (src_q.size() < 4 && p < 60) begin
                h = 8'($urandom);
                if ($urandom_range(0, 9) < 8) h[6:4] = 3'($urandom_range(0, 4));
                push(h);
                for (int k = 0; k < decode_cnt(h); k++) push(8'($urandom));
                p++;
            end
            // A client can only become full right after it was written.
            if (c1_full) c1_full = $urandom_range(0, 3) != 0;
            else if (last_w1) c1_full = $urandom_range(0, 2) == 0;
            if (c2_full) c2_full = $urandom_range(0, 3) != 0;
            else if (last_w2) c2_full = $urandom_range(0, 2) == 0;
            stall_empty = $urandom_range(0, 9) < 2;
            step();
        end
        c1_full = 1'b0;
        c2_full = 1'b0;
        stall_empty = 1'b0;
        run_idle(500);
        chk("rand_drain", 32'(exp_q.size()), 32'd0);
        chk("err_total", 32'(n_err), 32'(n_err_exp));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
